dmem_arbiter: RTL and testbench

- Shares the single data memory (data_mem) between two requesters. Port A is the pipeline MEM stage. Port B is the loader/debug port.
- Fixed A priority, with a starvation guard for B.
- Registers the selected command onto the data_mem inputs, captures readData, and returns it to the owning port with a valid pulse.
- Sits between the MEM stage / loader and data_mem. Drives the pipeline stall for A.

---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Request/response bundle for one requester of the data-memory arbiter.
//   One instance is used for the pipeline MEM stage (port A) and one for the
//   loader/debug port (port B).
//
//   Signals:
//     req     requester -> arbiter   request
//     rd      requester -> arbiter   read type  (00 none, 01 word, 10 byte, 11 illegal)
//     wr      requester -> arbiter   write type (same encoding)
//     addr    requester -> arbiter   address
//     wdata   requester -> arbiter   write data
//     gnt     arbiter -> requester   request accepted this cycle (combinational)
//     rvalid  arbiter -> requester   read data valid (one-cycle pulse)
//     rdata   arbiter -> requester   read data, held until the next response
//     stall   arbiter -> requester   valid request not granted this cycle
//
//   Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic [1:0]        rd;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              stall;

    modport master (
        output req, rd, wr, addr, wdata,
        input  gnt, rvalid, rdata, stall
    );

    modport slave (
        input  req, rd, wr, addr, wdata,
        output gnt, rvalid, rdata, stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares one data memory between the pipeline MEM stage (port A) and the
//   loader/debug port (port B). Port A has fixed priority; a starvation
//   counter forces a grant to B after STARVE_LIMIT consecutive A grants while
//   B was waiting. The granted command is registered onto the data_mem
//   inputs, the memory's read data is captured one cycle later and returned
//   to the owning port with a one-cycle rvalid pulse (grant-to-rvalid = 2).
//
//   Optional build macro:
//     DMEM_ARB_RR_EN  strict round-robin between A and B (last_owner bit)
//                     instead of A priority; the starvation counter and
//                     STARVE_LIMIT are then unused.
//
//   Ports:
//     clk        in   system clock, all state on rising edge
//     rst        in   synchronous active-high reset
//     port_a     slave modport of dmem_arbiter_if, MEM stage requester
//     port_b     slave modport of dmem_arbiter_if, loader/debug requester
//     mem_read   out  data_mem memRead
//     mem_write  out  data_mem memWrite
//     mem_addr   out  data_mem addr
//     mem_wdata  out  data_mem writeData
//     mem_rdata  in   data_mem readData, valid in the cycle mem_* are driven
//     err        out  one-cycle pulse: accepted op carried a 2'b11 field
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     port_a,
    dmem_arbiter_if.slave     port_b,
    output logic [1:0]        mem_read,
    output logic [1:0]        mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    logic              a_valid;
    logic              b_valid;
    logic              grant_a;
    logic              grant_b;
    logic              any_grant;
    logic [1:0]        sel_rd;
    logic [1:0]        sel_wr;
    logic [1:0]        clean_rd;
    logic [1:0]        clean_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_illegal;

    // Command stage registers (drive data_mem during the access cycle)
    logic [1:0]        cmd_read;
    logic [1:0]        cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    owner_t            cmd_owner;
    logic              cmd_rd_pend;
    logic              err_q;

    // Response stage registers
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

`ifdef DMEM_ARB_RR_EN
    owner_t            last_owner;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]        starve_cnt;
`endif

    // A request with both op fields 00 is not a request at all.
    always_comb begin
        a_valid = port_a.req && ((port_a.rd != 2'b00) || (port_a.wr != 2'b00));
        b_valid = port_b.req && ((port_b.rd != 2'b00) || (port_b.wr != 2'b00));
    end

    // Arbitration; nothing is granted while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
`ifdef DMEM_ARB_RR_EN
        // On a tie the port that did not win last time gets the grant.
        grant_a = a_valid && !(b_valid && (last_owner == OWNER_A));
        grant_b = b_valid && !grant_a;
`else
        // B is forced once A has won STARVE_LIMIT times in a row over it.
        grant_a = a_valid && !(b_valid && (starve_cnt == LIMIT));
        grant_b = b_valid && !grant_a;
`endif
        if (rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
        any_grant = grant_a || grant_b;
    end

    // Select the winning command and strip illegal 2'b11 fields.
    always_comb begin
        sel_rd      = grant_b ? port_b.rd    : port_a.rd;
        sel_wr      = grant_b ? port_b.wr    : port_a.wr;
        sel_addr    = grant_b ? port_b.addr  : port_a.addr;
        sel_wdata   = grant_b ? port_b.wdata : port_a.wdata;
        clean_rd    = (sel_rd == 2'b11) ? 2'b00 : sel_rd;
        clean_wr    = (sel_wr == 2'b11) ? 2'b00 : sel_wr;
        sel_illegal = any_grant && ((sel_rd == 2'b11) || (sel_wr == 2'b11));
    end

    // Command stage: address/data hold when idle so the memory bus stays quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_read    <= 2'b00;
            cmd_write   <= 2'b00;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            cmd_owner   <= OWNER_A;
            cmd_rd_pend <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cmd_read    <= any_grant ? clean_rd : 2'b00;
            cmd_write   <= any_grant ? clean_wr : 2'b00;
            cmd_owner   <= grant_b ? OWNER_B : OWNER_A;
            cmd_rd_pend <= any_grant && (clean_rd != 2'b00);
            err_q       <= sel_illegal;
            if (any_grant) begin
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
            end
        end
    end

    // Response stage: capture the memory's read data for the command's owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= cmd_rd_pend && (cmd_owner == OWNER_A);
            b_rvalid_q <= cmd_rd_pend && (cmd_owner == OWNER_B);
            if (cmd_rd_pend && (cmd_owner == OWNER_A)) begin
                a_rdata_q <= mem_rdata;
            end
            if (cmd_rd_pend && (cmd_owner == OWNER_B)) begin
                b_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_B;
        end else if (grant_a) begin
            last_owner <= OWNER_A;
        end else if (grant_b) begin
            last_owner <= OWNER_B;
        end
    end
`else
    // Counts A wins while B waits; any B win or B going idle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!b_valid || grant_b) begin
            starve_cnt <= 4'd0;
        end else if (grant_a && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Outputs are forced low while reset is held, so a write latched in the
    // cycle before reset never reaches data_mem.
    always_comb begin
        port_a.gnt    = grant_a;
        port_b.gnt    = grant_b;
        port_a.stall  = !rst && a_valid && !grant_a;
        port_b.stall  = !rst && b_valid && !grant_b;
        port_a.rvalid = !rst && a_rvalid_q;
        port_b.rvalid = !rst && b_rvalid_q;
        port_a.rdata  = rst ? '0 : a_rdata_q;
        port_b.rdata  = rst ? '0 : b_rdata_q;
        mem_read      = rst ? 2'b00 : cmd_read;
        mem_write     = rst ? 2'b00 : cmd_write;
        mem_addr      = rst ? '0 : cmd_addr;
        mem_wdata     = rst ? '0 : cmd_wdata;
        err           = !rst && err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter (default build, STARVE_LIMIT = 4).
//   Includes a behavioural data_mem: byte addressed, 16-bit words, word ops
//   use addr[8:1], byte ops use the byte selected by addr[0] and return it
//   zero-extended. Word k is preloaded with 16'h1000 + k.
//   Expected responses are queued when a grant is expected; a monitor pops
//   and compares whenever the DUT raises rvalid or err.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [1:0]        mem_read;
    logic [1:0]        mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .port_a   (ifa),
        .port_b   (ifb),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   qerr[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] words [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        for (int i = 0; i < 256; i++) words[i] = 16'h1000 + 16'(i);
    end

    // Behavioural data memory: combinational read, write on rising edge.
    always_comb begin
        mem_rdata = '0;
        if (mem_read == 2'b01) begin
            mem_rdata = words[mem_addr[8:1]];
        end else if (mem_read == 2'b10) begin
            mem_rdata = mem_addr[0] ? {8'h00, words[mem_addr[8:1]][15:8]}
                                    : {8'h00, words[mem_addr[8:1]][7:0]};
        end
    end

    always @(posedge clk) begin
        if (mem_write == 2'b01) begin
            words[mem_addr[8:1]] <= mem_wdata;
        end else if (mem_write == 2'b10) begin
            if (mem_addr[0]) words[mem_addr[8:1]][15:8] <= mem_wdata[7:0];
            else             words[mem_addr[8:1]][7:0]  <= mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response/err pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            e = qa.pop_front();
            check("a_rvalid_missing", 32'd0, 32'd1);
        end
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            e = qb.pop_front();
            check("b_rvalid_missing", 32'd0, 32'd1);
        end
        if (qerr.size() > 0 && qerr[0] < cyc) begin
            void'(qerr.pop_front());
            check("err_missing", 32'd0, 32'd1);
        end
        if (ifa.rvalid) begin
            if (qa.size() == 0) begin
                check("a_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rdata", 32'(ifa.rdata), 32'(e.data));
                check("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ifb.rvalid) begin
            if (qb.size() == 0) begin
                check("b_rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rdata", 32'(ifb.rdata), 32'(e.data));
                check("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (err) begin
            if (qerr.size() == 0) begin
                check("err_unexpected", 32'd1, 32'd0);
            end else begin
                check("err_cycle", 32'(cyc), 32'(qerr.pop_front()));
            end
        end
    end

    task automatic set_a(input logic req, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        ifa.req = req; ifa.rd = rd; ifa.wr = wr; ifa.addr = addr; ifa.wdata = wdata;
    endtask

    task automatic set_b(input logic req, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        ifb.req = req; ifb.rd = rd; ifb.wr = wr; ifb.addr = addr; ifb.wdata = wdata;
    endtask

    task automatic apply_stimulus_idle();
        set_a(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
        set_b(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
    endtask

    // Checks grant/stall for the current cycle, queues the expected response
    // of whichever port should be granted, then advances one clock.
    task automatic check_output(input string tag, input bit ga, input bit gb,
                                input bit sa, input bit sb,
                                input logic [15:0] da, input logic [15:0] db,
                                input bit track);
        exp_t e;
        @(negedge clk);
        check({tag, "_a_gnt"},   32'(ifa.gnt),   32'(ga));
        check({tag, "_b_gnt"},   32'(ifb.gnt),   32'(gb));
        check({tag, "_a_stall"}, 32'(ifa.stall), 32'(sa));
        check({tag, "_b_stall"}, 32'(ifb.stall), 32'(sb));
        if (ga) begin
            if (track && (ifa.rd == 2'b01 || ifa.rd == 2'b10)) begin
                e.data = da; e.cyc = cyc + 2; qa.push_back(e);
            end
            if (ifa.rd == 2'b11 || ifa.wr == 2'b11) qerr.push_back(cyc + 1);
        end
        if (gb) begin
            if (track && (ifb.rd == 2'b01 || ifb.rd == 2'b10)) begin
                e.data = db; e.cyc = cyc + 2; qb.push_back(e);
            end
            if (ifb.rd == 2'b11 || ifb.wr == 2'b11) qerr.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        apply_stimulus_idle();
        for (int i = 0; i < n; i++) check_output("idle", 0, 0, 0, 0, 16'h0, 16'h0, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_gnt"},    32'(ifa.gnt),    32'd0);
        check({tag, "_b_gnt"},    32'(ifb.gnt),    32'd0);
        check({tag, "_a_rvalid"}, 32'(ifa.rvalid), 32'd0);
        check({tag, "_a_rdata"},  32'(ifa.rdata),  32'd0);
        check({tag, "_b_rdata"},  32'(ifb.rdata),  32'd0);
        check({tag, "_mem_read"}, 32'(mem_read),   32'd0);
        check({tag, "_mem_write"},32'(mem_write),  32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},32'(mem_wdata),  32'd0);
        check({tag, "_err"},      32'(err),        32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ga;
        rst = 1'b1;
        apply_stimulus_idle();
        // Read requested while reset is held: never granted, never answered.
        set_a(1'b1, 2'b01, 2'b00, 16'd4, 16'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_zero_outputs("reset");
            @(posedge clk);
            #1;
        end
        apply_stimulus_idle();
        rst = 1'b0;
        idle_cycles(3);

        $display("[TB] word and byte write/read");
        set_a(1'b1, 2'b00, 2'b01, 16'd0, 16'hABCD);
        check_output("wr_word", 1, 0, 0, 0, 16'h0, 16'h0, 1);
        set_a(1'b1, 2'b01, 2'b00, 16'd0, 16'h0);
        check_output("rd_word", 1, 0, 0, 0, 16'hABCD, 16'h0, 1);
        set_a(1'b1, 2'b00, 2'b10, 16'd2, 16'h0E1A);
        check_output("wr_byte", 1, 0, 0, 0, 16'h0, 16'h0, 1);
        set_a(1'b1, 2'b10, 2'b00, 16'd2, 16'h0);
        check_output("rd_byte", 1, 0, 0, 0, 16'h001A, 16'h0, 1);
        idle_cycles(3);

        $display("[TB] B only");
        set_b(1'b1, 2'b01, 2'b00, 16'd8, 16'h0);
        check_output("b_only", 0, 1, 0, 0, 16'h0, 16'h1004, 1);
        idle_cycles(3);

        $display("[TB] contention");
        set_a(1'b1, 2'b01, 2'b00, 16'd8, 16'h0);
        set_b(1'b1, 2'b01, 2'b00, 16'd6, 16'h0);
        for (int i = 0; i < 10; i++) begin
            ga = (i != 4) && (i != 9);
            check_output("contend", ga, !ga, !ga, ga, 16'h1004, 16'h1003, 1);
        end
        idle_cycles(3);

        $display("[TB] empty and illegal ops");
        set_a(1'b1, 2'b00, 2'b00, 16'd0, 16'h0);
        check_output("empty", 0, 0, 0, 0, 16'h0, 16'h0, 1);
        set_a(1'b1, 2'b11, 2'b00, 16'd8, 16'h0);
        check_output("illegal", 1, 0, 0, 0, 16'h0, 16'h0, 1);
        apply_stimulus_idle();
        @(negedge clk);
        check("illegal_mem_read",  32'(mem_read),  32'd0);
        check("illegal_mem_write", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        idle_cycles(3);

        $display("[TB] reset during read");
        set_a(1'b1, 2'b01, 2'b00, 16'd8, 16'h0);
        check_output("mid_rd", 1, 0, 0, 0, 16'h0, 16'h0, 0);
        apply_stimulus_idle();
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid_rd_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(4);

        $display("[TB] reset during write");
        set_a(1'b1, 2'b00, 2'b01, 16'd0, 16'h5555);
        check_output("mid_wr", 1, 0, 0, 0, 16'h0, 16'h0, 1);
        apply_stimulus_idle();
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("mid_wr_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        set_a(1'b1, 2'b01, 2'b00, 16'd0, 16'h0);
        check_output("rd_after_rst", 1, 0, 0, 0, 16'hABCD, 16'h0, 1);
        idle_cycles(4);

        check("a_queue_drained",   32'(qa.size()),   32'd0);
        check("b_queue_drained",   32'(qb.size()),   32'd0);
        check("err_queue_drained", 32'(qerr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
